ds3231_wr_seq: RTL

Transaction sequencer that sits directly upstream of the DS3231 I2C byte-write engine. It holds that engine's `start` level and presents device/register/data bytes. After reset it runs a fixed two-write init sequence (control and status registers). On request it runs a seven-write time-set sequence (seconds..year, BCD). It sequences single writes one at a time, enforces an idle gap between them, and aborts a write that never completes (the engine retries NACKs indefinitely).

---
 rtl/ds3231_pkg.sv | 32 +++
 rtl/ds3231_wr_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ds3231_pkg.sv
// Shared constants and types for the DS3231 write sequencer.
package ds3231_pkg;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'hD0;

    localparam logic [7:0] REG_SEC   = 8'h00;
    localparam logic [7:0] REG_MIN   = 8'h01;
    localparam logic [7:0] REG_HOUR  = 8'h02;
    localparam logic [7:0] REG_DAY   = 8'h03;
    localparam logic [7:0] REG_DATE  = 8'h04;
    localparam logic [7:0] REG_MONTH = 8'h05;
    localparam logic [7:0] REG_YEAR  = 8'h06;
    localparam logic [7:0] REG_CTRL  = 8'h0E;
    localparam logic [7:0] REG_STAT  = 8'h0F;

    localparam logic [2:0] INIT_LEN = 3'd2;
    localparam logic [2:0] TSET_LEN = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StGap,
        StFinish
    } wr_state_e;

    typedef enum logic {
        SeqInit,
        SeqTset
    } seq_sel_e;

endpackage

// File: rtl/ds3231_wr_seq.sv
// Sequences DS3231 register writes (init after reset, time-set on request) into a
// single-byte write engine, with inter-write gap and per-write timeout.
module ds3231_wr_seq
    import ds3231_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter logic [7:0]  CTRL_INIT   = 8'h1C,
    parameter logic [7:0]  STAT_INIT   = 8'h00,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_day,
    input  logic [7:0] set_date,
    input  logic [7:0] set_month,
    input  logic [7:0] set_year,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       init_ok,
    output logic       wr_start,
    output logic [7:0] wr_dev,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_over
);

    localparam int unsigned    CntW         = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYC - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

    wr_state_e       state_q, state_d;
    seq_sel_e        seq_sel_q, seq_sel_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            abort_q, abort_d;
    logic            init_pend_q, init_pend_d;
    logic            init_ok_q, init_ok_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [6:0][7:0] tset_q, tset_d;

    logic [2:0]      seq_len;
    logic [7:0]      entry_addr;
    logic [7:0]      entry_data;

    assign seq_len = (seq_sel_q == SeqInit) ? INIT_LEN : TSET_LEN;

    // Entry mux on {seq_sel, idx}
    always_comb begin
        entry_addr = 8'h00;
        entry_data = 8'h00;
        if (seq_sel_q == SeqInit) begin
            case (idx_q)
                3'd0: begin entry_addr = REG_CTRL;  entry_data = CTRL_INIT;  end
                3'd1: begin entry_addr = REG_STAT;  entry_data = STAT_INIT;  end
                default: ;
            endcase
        end else begin
            case (idx_q)
                3'd0: begin entry_addr = REG_SEC;   entry_data = tset_q[0]; end
                3'd1: begin entry_addr = REG_MIN;   entry_data = tset_q[1]; end
                3'd2: begin entry_addr = REG_HOUR;  entry_data = tset_q[2]; end
                3'd3: begin entry_addr = REG_DAY;   entry_data = tset_q[3]; end
                3'd4: begin entry_addr = REG_DATE;  entry_data = tset_q[4]; end
                3'd5: begin entry_addr = REG_MONTH; entry_data = tset_q[5]; end
                3'd6: begin entry_addr = REG_YEAR;  entry_data = tset_q[6]; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_sel_d   = seq_sel_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        init_pend_d = init_pend_q;
        init_ok_d   = init_ok_q;
        busy_d      = busy_q;
        tset_d      = tset_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (init_pend_q) begin
                    state_d   = StLoad;
                    seq_sel_d = SeqInit;
                    idx_d     = 3'd0;
                    abort_d   = 1'b0;
                    busy_d    = 1'b1;
                end else if (set_req) begin
                    state_d   = StLoad;
                    seq_sel_d = SeqTset;
                    idx_d     = 3'd0;
                    abort_d   = 1'b0;
                    busy_d    = 1'b1;
                    tset_d    = {set_year, set_month, set_date, set_day,
                                 set_hour, set_min, set_sec};
                end
            end
            StLoad: begin
                state_d = StIssue;
                cnt_d   = '0;
            end
            StIssue: begin
                // A completion on the timeout edge wins over the timeout
                if (wr_over) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    if (seq_sel_q == SeqInit) begin
                        init_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    if (abort_q) begin
                        state_d = StIdle;
                    end else if (idx_q == seq_len) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (seq_sel_q == SeqInit) begin
                            init_pend_d = 1'b0;
                            init_ok_d   = 1'b1;
                        end
                    end else begin
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            seq_sel_q   <= SeqInit;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            init_pend_q <= 1'b1;
            init_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tset_q      <= '0;
        end else begin
            state_q     <= state_d;
            seq_sel_q   <= seq_sel_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            init_pend_q <= init_pend_d;
            init_ok_q   <= init_ok_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tset_q      <= tset_d;
        end
    end

    // wr_start is decoded from the state flop so reset drops it asynchronously
    assign wr_start = (state_q == StIssue);
    assign wr_dev   = DEV_ADDR;
    assign wr_addr  = (state_q == StLoad || state_q == StIssue) ? entry_addr : 8'h00;
    assign wr_data  = (state_q == StLoad || state_q == StIssue) ? entry_data : 8'h00;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign init_ok  = init_ok_q;

endmodule
